parity_frame_rx: RTL and testbench

Serial frame receiver and checker for the even-parity nibble link. The transmitter side computes the parity bit as the XOR of the data bits. This block deserialises start/data/parity/stop frames, checks parity and framing, and presents good words on a valid/ready output port. It keeps a saturating error counter that firmware can clear.

---
 rtl/parity_rx_pkg.sv | 24 ++
 rtl/sat_counter.sv | 27 ++
 rtl/parity_frame_rx.sv | 136 +++++++++++++
 tb/tb_parity_frame_rx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/parity_rx_pkg.sv
// Shared types and helpers for the even-parity nibble link receiver.
// Holds the FSM state type, the parity function and the counter saturation pattern.
package parity_rx_pkg;

    localparam int MAX_DATA_W = 32;
    localparam int MAX_CNT_W  = 32;

    // Counters narrower than MAX_CNT_W saturate at the low W bits of this pattern.
    localparam logic [MAX_CNT_W-1:0] CNT_SAT = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    // Zero-extension of a narrower word leaves the XOR unchanged.
    function automatic logic even_parity(input logic [MAX_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that beats a coincident increment.
module sat_counter
    import parity_rx_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] SAT = CNT_SAT[W-1:0];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != SAT)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/parity_frame_rx.sv
// Start/data/parity/stop frame receiver with parity and framing checks,
// a one-deep valid/ready holding register and a saturating error counter.
module parity_frame_rx
    import parity_rx_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              bit_en,
    input  logic              rx,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              par_err,
    output logic              frame_err,
    output logic              overrun,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    rx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W:0]   shift_cat;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              parity_q, parity_d;
    logic [DATA_W-1:0] data_d;
    logic              valid_d;
    logic              par_err_d, frame_err_d, overrun_d;
    logic              err_inc;

    assign shift_cat = {rx, shift_q};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            parity_q  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            parity_q  <= parity_d;
            out_data  <= data_d;
            out_valid <= valid_d;
            par_err   <= par_err_d;
            frame_err <= frame_err_d;
            overrun   <= overrun_d;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d     = state_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        parity_d    = parity_q;
        data_d      = out_data;
        valid_d     = out_valid;
        par_err_d   = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        err_inc     = 1'b0;

        if (out_valid && out_ready) begin
            valid_d = 1'b0;
        end

        if (bit_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rx) begin
                        shift_d = '0;
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    // LSB-first: each new bit enters at the top and drifts down.
                    shift_d = shift_cat[DATA_W:1];
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_d = rx;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    if (!rx) begin
                        frame_err_d = 1'b1;
                        err_inc     = 1'b1;
                        state_d     = ST_WAIT_IDLE;
                    end else begin
                        state_d = ST_IDLE;
                        if (parity_q != even_parity(MAX_DATA_W'(shift_q))) begin
                            par_err_d = 1'b1;
                            err_inc   = 1'b1;
                        end else if (!out_valid || out_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (err_inc),
        .clr    (err_clr),
        .cnt    (err_cnt)
    );

endmodule

// File: tb/tb_parity_frame_rx.sv
// Self-checking bench for parity_frame_rx: directed frame table, hand-written
// corner sequences and randomized frames against a frame-level reference model.
module tb_parity_frame_rx;

    localparam int DATA_W  = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    logic              clk = 1'b0;
    logic              resetn;
    logic              bit_en;
    logic              rx;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              par_err;
    logic              frame_err;
    logic              overrun;
    logic              err_clr;
    logic [CNT_W-1:0]  err_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model state: what the holding register and counter should contain.
    logic       m_valid;
    logic [3:0] m_data;
    int         m_cnt;

    always #5 clk = ~clk;

    parity_frame_rx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bit_en    (bit_en),
        .rx        (rx),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .par_err   (par_err),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr),
        .err_cnt   (err_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, predict outputs after the edge, compare.
    task automatic step(input logic be, input logic r, input logic rdy, input logic clr,
                        input logic is_stop, input logic [3:0] d, input logic p);
        logic hs, good, e_pe, e_fe, e_ov;
        bit_en = be; rx = r; out_ready = rdy; err_clr = clr;
        hs = m_valid && rdy;
        good = 1'b0; e_pe = 1'b0; e_fe = 1'b0; e_ov = 1'b0;
        if (be && is_stop) begin
            if (!r)           e_fe = 1'b1;
            else if (p != ^d) e_pe = 1'b1;
            else              good = 1'b1;
        end
        if (good) begin
            if (!m_valid || hs) begin
                m_data  = d;
                m_valid = 1'b1;
            end else begin
                e_ov = 1'b1;
            end
        end else if (hs) begin
            m_valid = 1'b0;
        end
        if (clr)                                m_cnt = 0;
        else if ((e_pe || e_fe) && m_cnt < CNT_MAX) m_cnt++;
        @(posedge clk); #1;
        check("cycle {valid,data,pe,fe,ov,cnt}",
              {22'd0, out_valid, out_data, par_err, frame_err, overrun, err_cnt},
              {22'd0, m_valid, m_data, e_pe, e_fe, e_ov, 2'(m_cnt)});
    endtask

    function automatic logic pick_rdy(input int mode);
        if (mode == 2) return logic'($urandom_range(0, 1));
        return (mode != 0);
    endfunction

    // rdy_mode: 0/1 hold out_ready at that value, 2 randomize it every cycle.
    task automatic send_frame(input logic [3:0] d, input logic p, input logic s,
                              input int rdy_mode, input int gap, input logic clr_at_stop);
        logic b [7];
        b[0] = 1'b0;
        for (int i = 0; i < 4; i++) b[i+1] = d[i];
        b[5] = p;
        b[6] = s;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, b[i], pick_rdy(rdy_mode), clr_at_stop && (i == 6), i == 6, d, p);
            for (int g = 1; g < gap; g++)
                step(1'b0, b[i], pick_rdy(rdy_mode), 1'b0, 1'b0, d, p);
        end
    endtask

    task automatic line_bits(input logic val, input int n, input int rdy_mode);
        for (int i = 0; i < n; i++) step(1'b1, val, pick_rdy(rdy_mode), 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    typedef struct {
        logic [3:0] d;
        logic       p;
        logic       s;
        logic       pre_rdy;
        logic       rdy;
        int         zeros_after;
        logic       e_valid;
        logic [3:0] e_data;
        logic       e_pe;
        logic       e_fe;
        logic       e_ov;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t vecs [6];

    initial begin
        // good B; parity error 6; framing error 2 + held zeros; good 9; 3 then 5 -> overrun
        vecs[0] = '{4'hB, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[1] = '{4'h6, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0, 4'hB, 1'b1, 1'b0, 1'b0, 2'd1};
        vecs[2] = '{4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 3, 1'b0, 4'hB, 1'b0, 1'b1, 1'b0, 2'd2};
        vecs[3] = '{4'h9, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 2'd2};
        vecs[4] = '{4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 2'd2};
        vecs[5] = '{4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 2'd2};

        resetn = 1'b0; bit_en = 1'b0; rx = 1'b1; out_ready = 1'b0; err_clr = 1'b0;
        m_valid = 1'b0; m_data = 4'h0; m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", {out_valid, out_data, par_err, frame_err, overrun, err_cnt}, 32'd0);
        resetn = 1'b1;

        // Directed frame table
        for (int i = 0; i < 6; i++) begin
            line_bits(1'b1, 2, int'(vecs[i].pre_rdy));
            send_frame(vecs[i].d, vecs[i].p, vecs[i].s, int'(vecs[i].rdy), 1, 1'b0);
            check($sformatf("vec%0d {valid,data,pe,fe,ov,cnt}", i),
                  {out_valid, out_data, par_err, frame_err, overrun, err_cnt},
                  {vecs[i].e_valid, vecs[i].e_data, vecs[i].e_pe, vecs[i].e_fe,
                   vecs[i].e_ov, vecs[i].e_cnt});
            line_bits(1'b0, vecs[i].zeros_after, int'(vecs[i].rdy));
        end
        check("overrun keeps data", out_data, 4'h3);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        check("handshake clears valid", out_valid, 1'b0);

        // Saturation and clear priority
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
        check("err_clr", err_cnt, 2'd0);
        for (int i = 0; i < 5; i++) send_frame(4'h6, 1'b1, 1'b1, 0, 1, 1'b0);
        check("saturated cnt", err_cnt, 2'd3);
        send_frame(4'h6, 1'b1, 1'b1, 0, 1, 1'b1);
        check("clr beats inc: cnt", err_cnt, 2'd0);
        check("clr beats inc: par_err", par_err, 1'b1);

        // Asynchronous reset mid-frame with sparse strobes
        send_frame(4'h7, 1'b1, 1'b1, 0, 1, 1'b0);
        send_frame(4'h6, 1'b1, 1'b1, 0, 1, 1'b0);
        check("pre-reset valid", out_valid, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
            repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        end
        resetn = 1'b0;
        #2;
        check("async reset outputs", {out_valid, out_data, par_err, frame_err, overrun, err_cnt}, 32'd0);
        m_valid = 1'b0; m_data = 4'h0; m_cnt = 0;
        @(posedge clk); #1;
        resetn = 1'b1;
        line_bits(1'b1, 2, 0);
        send_frame(4'hA, 1'b0, 1'b1, 0, 4, 1'b0);
        check("post-reset frame", {out_valid, out_data}, {1'b1, 4'hA});

        // Randomized frames against the reference model
        for (int k = 0; k < 300; k++) begin
            logic [3:0] d;
            logic p, s;
            d = 4'($urandom);
            p = (^d) ^ ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 4) != 0);
            send_frame(d, p, s, 2, $urandom_range(1, 3), $urandom_range(0, 7) == 0);
            if (!s) begin
                line_bits(1'b0, $urandom_range(0, 3), 2);
                line_bits(1'b1, $urandom_range(1, 2), 2);
            end else begin
                line_bits(1'b1, $urandom_range(0, 2), 2);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
